// File: rtl/pmem_arb_if.sv
// pmem_arb_if: request/response and memory-strobe bundle between the IFU,
// the LSU, the pmem DPI wrapper and pmem_arbiter.
//   slave  modport: arbiter side (takes requests and mem_rdata, drives
//                   ready/response signals and the memory strobes)
//   master modport: requester/memory side (the opposite directions)
// Signals:
//   ifu_req_valid/ifu_req_ready/ifu_addr              IFU read request
//   ifu_resp_valid/ifu_resp_ready/ifu_rdata           IFU read response
//   lsu_req_valid/lsu_req_ready/lsu_addr/lsu_wen/
//   lsu_wdata/lsu_wmask                               LSU request
//   lsu_resp_valid/lsu_resp_ready/lsu_rdata           LSU response
//   mem_raddr/mem_rvalid/mem_rdata                    pmem read port
//   mem_waddr/mem_wdata/mem_wmask                     pmem write port
interface pmem_arb_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   localparam int MASK_W = DATA_W / 8;

   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic              ifu_resp_ready;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_resp_valid;
   logic              lsu_resp_ready;
   logic [DATA_W-1:0] lsu_rdata;

   logic [ADDR_W-1:0] mem_raddr;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;

   modport slave (
      input  ifu_req_valid, ifu_addr, ifu_resp_ready,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
      input  mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output ifu_req_valid, ifu_addr, ifu_resp_ready,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
      output mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single pmem DPI port between the IFU and the LSU.
// One transaction at a time: accept in IDLE, wait LATENCY cycles (the last of
// which strobes the memory), then hold the response until it is consumed.
// Ports:
//   clock  core clock
//   reset  synchronous, active-high reset
//   bus    pmem_arb_if.slave (IFU/LSU handshakes and pmem strobes)
// Parameters: LATENCY (1..15), ADDR_W, DATA_W.
// Build option: define PMEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requesters; otherwise the LSU always wins over the IFU.
module pmem_arbiter #(
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
) (
   input  logic         clock,
   input  logic         reset,
   pmem_arb_if.slave    bus
);
   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("pmem_arbiter: LATENCY must be in 1..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wen_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] ifu_rdata_q;
   logic [DATA_W-1:0] lsu_rdata_q;

   logic grant_lsu;
   logic accept_lsu;
   logic accept_ifu;
   logic fire;

`ifdef PMEM_ARB_RR_EN
   logic last_owner_q;
   // With both requesting, the LSU only wins if the IFU was served last.
   always_comb grant_lsu = bus.lsu_req_valid && !(bus.ifu_req_valid && (last_owner_q == OWN_LSU));
`else
   always_comb grant_lsu = bus.lsu_req_valid;
`endif

   always_comb begin
      state_d    = state_q;
      accept_lsu = 1'b0;
      accept_ifu = 1'b0;
      fire       = 1'b0;
      case (state_q)
         IDLE: begin
            accept_lsu = grant_lsu && !reset;
            accept_ifu = !grant_lsu && bus.ifu_req_valid && !reset;
            if (accept_lsu || accept_ifu) state_d = WAIT;
         end
         WAIT: begin
            // The final WAIT cycle is the single cycle the memory is strobed.
            if (cnt_q == '0) begin
               fire    = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if ((owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IFU;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         cnt_q       <= '0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
         last_owner_q <= OWN_IFU;
`endif
      end else begin
         state_q <= state_d;
         if (accept_lsu || accept_ifu) begin
            owner_q <= accept_lsu ? OWN_LSU : OWN_IFU;
            addr_q  <= accept_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q   <= accept_lsu && bus.lsu_wen;
            wdata_q <= accept_lsu ? bus.lsu_wdata : '0;
            wmask_q <= accept_lsu ? bus.lsu_wmask : '0;
            cnt_q   <= CNT_LOAD;
`ifdef PMEM_ARB_RR_EN
            last_owner_q <= accept_lsu ? OWN_LSU : OWN_IFU;
`endif
         end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (fire) begin
            if (owner_q == OWN_LSU) lsu_rdata_q <= wen_q ? '0 : bus.mem_rdata;
            else                    ifu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.ifu_req_ready  = accept_ifu;
   assign bus.lsu_req_ready  = accept_lsu;
   assign bus.ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
   assign bus.lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
   assign bus.ifu_rdata      = ifu_rdata_q;
   assign bus.lsu_rdata      = lsu_rdata_q;

   // The pmem write is combinational on mem_wmask, so both strobes are gated
   // by reset directly to guarantee no stray access while reset is asserted.
   assign bus.mem_rvalid = fire && !wen_q && !reset;
   assign bus.mem_wmask  = (fire && wen_q && !reset) ? wmask_q : '0;
   assign bus.mem_raddr  = addr_q;
   assign bus.mem_waddr  = addr_q;
   assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: self-checking bench for pmem_arbiter (LATENCY = 3).
// Directed per-cycle vector table, hand-written multi-cycle sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_pmem_arbiter;
   localparam int LAT = 3;

   localparam logic        T   = 1'b1;
   localparam logic        F   = 1'b0;
   localparam logic [63:0] Z   = 64'h0;
   localparam logic [63:0] IA  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LA1 = 64'h0000_0000_8000_0800;
   localparam logic [63:0] LA2 = 64'h0000_0000_8000_1000;
   localparam logic [63:0] LA3 = 64'h0000_0000_8000_2000;
   localparam logic [63:0] DI  = 64'h0000_0013_0000_0297;
   localparam logic [63:0] DX  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] DY  = 64'hCAFE_F00D_1234_5678;
   localparam logic [63:0] WD  = 64'h0000_0000_DEAD_BEEF;
   localparam logic [63:0] WD3 = 64'h0000_0000_0000_1234;
   localparam logic [7:0]  M0  = 8'h00;
   localparam logic [7:0]  MF  = 8'h0F;

   logic clock;
   logic reset;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   pmem_arb_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   pmem_arbiter #(.LATENCY(LAT), .ADDR_W(64), .DATA_W(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [63:0] ia, input logic irr,
                        input logic lv, input logic lw, input logic [63:0] la,
                        input logic [63:0] wd, input logic [7:0] wm, input logic lrr,
                        input logic [63:0] rd);
      bus.ifu_req_valid  = iv;
      bus.ifu_addr       = ia;
      bus.ifu_resp_ready = irr;
      bus.lsu_req_valid  = lv;
      bus.lsu_wen        = lw;
      bus.lsu_addr       = la;
      bus.lsu_wdata      = wd;
      bus.lsu_wmask      = wm;
      bus.lsu_resp_ready = lrr;
      bus.mem_rdata      = rd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(F, Z, F, F, F, Z, Z, M0, F, Z);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic iv; logic [63:0] ia; logic irr;
      logic lv; logic lw; logic [63:0] la; logic [63:0] wd; logic [7:0] wm; logic lrr;
      logic [63:0] rd;
      logic e_ir; logic e_lr; logic e_rv; logic [7:0] e_wm; logic [63:0] e_wd;
      logic e_iv; logic e_lv; logic [63:0] e_ird; logic [63:0] e_lrd; logic [63:0] e_addr;
   } vec_t;

   vec_t tbl [22];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      // reference model state (transaction level)
      logic        busy, own_lsu, t_wen, last_lsu;
      logic [63:0] m_addr, t_wdata, m_ird, m_lrd;
      logic [7:0]  t_mask;
      int          age;
      logic        alt_exp [3];
      logic        gl [3];
      int          gcyc [3];
      int          gcnt, lat, early;

      //          iv ia  irr lv lw la   wd   wm  lrr rd  | e_ir e_lr e_rv e_wm e_wd e_iv e_lv e_ird e_lrd e_addr
      tbl[0]  = '{T, IA, F,  F, F, Z,   Z,   M0, F,  DX,   T,   F,   F,   M0,  Z,   F,   F,   Z,    Z,    Z  };
      tbl[1]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   Z,    Z,    IA };
      tbl[2]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   Z,    Z,    IA };
      tbl[3]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DI,   F,   F,   T,   M0,  Z,   F,   F,   Z,    Z,    IA };
      tbl[4]  = '{F, Z,  T,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   T,   F,   DI,   Z,    IA };
      tbl[5]  = '{F, Z,  F,  T, F, LA1, Z,   M0, F,  DX,   F,   T,   F,   M0,  Z,   F,   F,   DI,   Z,    IA };
      tbl[6]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA1};
      tbl[7]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA1};
      tbl[8]  = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DY,   F,   F,   T,   M0,  Z,   F,   F,   DI,   Z,    LA1};
      tbl[9]  = '{T, IA, F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   T,   DI,   DY,   LA1};
      tbl[10] = '{T, IA, F,  F, F, Z,   Z,   M0, T,  DX,   F,   F,   F,   M0,  Z,   F,   T,   DI,   DY,   LA1};
      tbl[11] = '{F, Z,  F,  T, T, LA2, WD,  MF, F,  DX,   F,   T,   F,   M0,  Z,   F,   F,   DI,   DY,   LA1};
      tbl[12] = '{T, IA, F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   DY,   LA2};
      tbl[13] = '{T, IA, F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   DY,   LA2};
      tbl[14] = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   MF,  WD,  F,   F,   DI,   DY,   LA2};
      tbl[15] = '{F, Z,  F,  F, F, Z,   Z,   M0, T,  DX,   F,   F,   F,   M0,  Z,   F,   T,   DI,   Z,    LA2};
      tbl[16] = '{F, Z,  F,  T, T, LA3, WD3, M0, F,  DX,   F,   T,   F,   M0,  Z,   F,   F,   DI,   Z,    LA2};
      tbl[17] = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA3};
      tbl[18] = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA3};
      tbl[19] = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DY,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA3};
      tbl[20] = '{F, Z,  F,  F, F, Z,   Z,   M0, T,  DX,   F,   F,   F,   M0,  Z,   F,   T,   DI,   Z,    LA3};
      tbl[21] = '{F, Z,  F,  F, F, Z,   Z,   M0, F,  DX,   F,   F,   F,   M0,  Z,   F,   F,   DI,   Z,    LA3};

      // ---------------- reset state ----------------
      do_reset();
      @(negedge clock);
      chk1 ("rst_ifu_req_ready",  bus.ifu_req_ready,  F);
      chk1 ("rst_lsu_req_ready",  bus.lsu_req_ready,  F);
      chk1 ("rst_ifu_resp_valid", bus.ifu_resp_valid, F);
      chk1 ("rst_lsu_resp_valid", bus.lsu_resp_valid, F);
      chk1 ("rst_mem_rvalid",     bus.mem_rvalid,     F);
      chk8 ("rst_mem_wmask",      bus.mem_wmask,      M0);
      chk64("rst_ifu_rdata",      bus.ifu_rdata,      Z);
      chk64("rst_lsu_rdata",      bus.lsu_rdata,      Z);
      chk64("rst_mem_raddr",      bus.mem_raddr,      Z);
      chk64("rst_mem_wdata",      bus.mem_wdata,      Z);
      @(posedge clock); #1;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].iv, tbl[i].ia, tbl[i].irr, tbl[i].lv, tbl[i].lw, tbl[i].la,
               tbl[i].wd, tbl[i].wm, tbl[i].lrr, tbl[i].rd);
         @(negedge clock);
         chk1 ($sformatf("v%0d_ifu_req_ready", i),  bus.ifu_req_ready,  tbl[i].e_ir);
         chk1 ($sformatf("v%0d_lsu_req_ready", i),  bus.lsu_req_ready,  tbl[i].e_lr);
         chk1 ($sformatf("v%0d_mem_rvalid", i),     bus.mem_rvalid,     tbl[i].e_rv);
         chk8 ($sformatf("v%0d_mem_wmask", i),      bus.mem_wmask,      tbl[i].e_wm);
         chk1 ($sformatf("v%0d_ifu_resp_valid", i), bus.ifu_resp_valid, tbl[i].e_iv);
         chk1 ($sformatf("v%0d_lsu_resp_valid", i), bus.lsu_resp_valid, tbl[i].e_lv);
         chk64($sformatf("v%0d_ifu_rdata", i),      bus.ifu_rdata,      tbl[i].e_ird);
         chk64($sformatf("v%0d_lsu_rdata", i),      bus.lsu_rdata,      tbl[i].e_lrd);
         chk64($sformatf("v%0d_mem_raddr", i),      bus.mem_raddr,      tbl[i].e_addr);
         chk64($sformatf("v%0d_mem_waddr", i),      bus.mem_waddr,      tbl[i].e_addr);
         if (tbl[i].e_wm != M0)
            chk64($sformatf("v%0d_mem_wdata", i),   bus.mem_wdata,      tbl[i].e_wd);
         @(posedge clock); #1;
      end

      // ---------------- both valid after reset: LSU first, then IFU ----------------
      do_reset();
      drive(T, IA, T, T, F, LA1, Z, M0, T, DX);
      @(negedge clock);
      chk1("arb_first_lsu_ready", bus.lsu_req_ready, T);
      chk1("arb_first_ifu_ready", bus.ifu_req_ready, F);
      @(posedge clock); #1;
      bus.lsu_req_valid = F;
      lat = -1;
      early = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (bus.ifu_req_ready) early++;
         if (bus.lsu_resp_valid) begin
            lat = n;
            break;
         end
         @(posedge clock); #1;
      end
      chk64("arb_lsu_resp_latency", 64'(lat), 64'(LAT + 1));
      chk64("arb_ifu_held_off", 64'(early), 64'(0));
      @(posedge clock); #1;
      @(negedge clock);
      chk1("arb_ifu_after_lsu", bus.ifu_req_ready, T);
      @(posedge clock); #1;

      // ---------------- both continuously valid: grant order and spacing ----------------
`ifdef PMEM_ARB_RR_EN
      alt_exp = '{T, F, T};
`else
      alt_exp = '{T, T, T};
`endif
      do_reset();
      drive(T, IA, T, T, F, LA1, Z, M0, T, DX);
      gcnt = 0;
      for (int n = 0; n < 60 && gcnt < 3; n++) begin
         @(negedge clock);
         if (bus.lsu_req_ready || bus.ifu_req_ready) begin
            gl[gcnt]   = bus.lsu_req_ready;
            gcyc[gcnt] = n;
            gcnt++;
         end
         @(posedge clock); #1;
      end
      chk64("alt_grant_count", 64'(gcnt), 64'(3));
      for (int i = 0; i < gcnt; i++) begin
         chk1($sformatf("alt_grant%0d_is_lsu", i), gl[i], alt_exp[i]);
         if (i > 0)
            chk64($sformatf("alt_grant%0d_spacing", i), 64'(gcyc[i] - gcyc[i-1]), 64'(LAT + 2));
      end

      // ---------------- response backpressure ----------------
      do_reset();
      drive(T, IA, F, F, F, Z, Z, M0, F, DX);
      @(negedge clock);
      chk1("bp_accept", bus.ifu_req_ready, T);
      @(posedge clock); #1;
      bus.ifu_req_valid = F;
      bus.mem_rdata     = DY;
      repeat (LAT) @(posedge clock);
      #1;
      bus.ifu_req_valid = T;
      bus.lsu_req_valid = T;
      bus.lsu_addr      = LA1;
      for (int n = 0; n < 5; n++) begin
         bus.mem_rdata = {$urandom(), $urandom()};
         @(negedge clock);
         chk1 ($sformatf("bp%0d_ifu_resp_valid", n), bus.ifu_resp_valid, T);
         chk64($sformatf("bp%0d_ifu_rdata", n),      bus.ifu_rdata,      DY);
         chk1 ($sformatf("bp%0d_ifu_req_ready", n),  bus.ifu_req_ready,  F);
         chk1 ($sformatf("bp%0d_lsu_req_ready", n),  bus.lsu_req_ready,  F);
         chk1 ($sformatf("bp%0d_mem_rvalid", n),     bus.mem_rvalid,     F);
         @(posedge clock); #1;
      end
      bus.ifu_resp_ready = T;
      @(negedge clock);
      chk1("bp_release_valid", bus.ifu_resp_valid, T);
      @(posedge clock); #1;
      bus.ifu_resp_ready = F;
      @(negedge clock);
      chk1("bp_next_lsu_grant", bus.lsu_req_ready, T);
      chk1("bp_resp_dropped",   bus.ifu_resp_valid, F);
      @(posedge clock); #1;

      // ---------------- reset during the strobe cycle of a write ----------------
      do_reset();
      drive(F, Z, F, T, T, LA2, WD, 8'hFF, T, DX);
      @(negedge clock);
      chk1("rw_accept", bus.lsu_req_ready, T);
      @(posedge clock); #1;
      bus.lsu_req_valid = F;
      for (int n = 1; n < LAT; n++) begin
         @(negedge clock);
         chk8($sformatf("rw_wait%0d_wmask", n), bus.mem_wmask, M0);
         @(posedge clock); #1;
      end
      reset = 1'b1;
      @(negedge clock);
      chk8("rw_wmask_forced", bus.mem_wmask, M0);
      chk1("rw_rvalid_forced", bus.mem_rvalid, F);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clock);
         chk1($sformatf("rw_post%0d_lsu_resp_valid", n), bus.lsu_resp_valid, F);
         chk8($sformatf("rw_post%0d_wmask", n), bus.mem_wmask, M0);
         if (n == 0) begin
            chk64("rw_post_raddr",     bus.mem_raddr, Z);
            chk64("rw_post_wdata",     bus.mem_wdata, Z);
            chk64("rw_post_lsu_rdata", bus.lsu_rdata, Z);
         end
         @(posedge clock); #1;
      end

      // ---------------- randomized traffic vs. reference model ----------------
      do_reset();
      busy = F; own_lsu = F; t_wen = F; last_lsu = F;
      m_addr = Z; t_wdata = Z; m_ird = Z; m_lrd = Z; t_mask = M0; age = 0;
      for (int c = 0; c < 400; c++) begin
         logic g_lsu, g_ifu, fire, resp;
         drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
               {$urandom(), $urandom()}, 8'($urandom()), 1'($urandom_range(0, 3) != 0),
               {$urandom(), $urandom()});
         @(negedge clock);
         fire  = busy && (age == LAT);
         resp  = busy && (age > LAT);
         g_lsu = F;
         g_ifu = F;
         if (!busy) begin
`ifdef PMEM_ARB_RR_EN
            if (bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu)) g_lsu = T;
            else if (bus.ifu_req_valid) g_ifu = T;
`else
            if (bus.lsu_req_valid) g_lsu = T;
            else if (bus.ifu_req_valid) g_ifu = T;
`endif
         end
         chk1 ($sformatf("r%0d_ifu_req_ready", c),  bus.ifu_req_ready,  g_ifu);
         chk1 ($sformatf("r%0d_lsu_req_ready", c),  bus.lsu_req_ready,  g_lsu);
         chk1 ($sformatf("r%0d_mem_rvalid", c),     bus.mem_rvalid,     fire && !t_wen);
         chk8 ($sformatf("r%0d_mem_wmask", c),      bus.mem_wmask,      (fire && t_wen) ? t_mask : M0);
         chk1 ($sformatf("r%0d_ifu_resp_valid", c), bus.ifu_resp_valid, resp && !own_lsu);
         chk1 ($sformatf("r%0d_lsu_resp_valid", c), bus.lsu_resp_valid, resp && own_lsu);
         chk64($sformatf("r%0d_ifu_rdata", c),      bus.ifu_rdata,      m_ird);
         chk64($sformatf("r%0d_lsu_rdata", c),      bus.lsu_rdata,      m_lrd);
         chk64($sformatf("r%0d_mem_raddr", c),      bus.mem_raddr,      m_addr);
         if (fire && t_wen)
            chk64($sformatf("r%0d_mem_wdata", c),   bus.mem_wdata,      t_wdata);
         if (fire) begin
            if (own_lsu) m_lrd = t_wen ? Z : bus.mem_rdata;
            else         m_ird = bus.mem_rdata;
         end
         if (resp && (own_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready)) busy = F;
         else if (busy) age++;
         if (g_lsu || g_ifu) begin
            busy     = T;
            age      = 1;
            own_lsu  = g_lsu;
            t_wen    = g_lsu && bus.lsu_wen;
            m_addr   = g_lsu ? bus.lsu_addr : bus.ifu_addr;
            t_wdata  = bus.lsu_wdata;
            t_mask   = bus.lsu_wmask;
            last_lsu = g_lsu;
         end
         @(posedge clock); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single DPI physical-memory port between two requesters: instruction fetch (IFU) and load/store unit (LSU).
- Uses a valid/ready request and response handshake per requester.
- Sequences one transaction at a time with a configurable access latency, and drives the memory's read-enable, write-mask and address/data strobes.
- Sits between the IFU/LSU and the pmem DPI wrapper in the NPC core.

Parameters:
- LATENCY, 1, memory access cycles between request acceptance and data capture; legal range 1..15.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; mask width is DATA_W/8.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  64  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU consumes response
- ifu_rdata  out  64  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  64  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  64  write data
- lsu_wmask  in  8  byte write mask
- lsu_resp_valid  out  1  LSU response valid (read data or write ack)
- lsu_resp_ready  in  1  LSU consumes response
- lsu_rdata  out  64  LSU read data; 0 for writes
- mem_raddr  out  64  to pmem read address
- mem_rvalid  out  1  to pmem read enable
- mem_rdata  in  64  from pmem read data
- mem_waddr  out  64  to pmem write address
- mem_wdata  out  64  to pmem write data
- mem_wmask  out  8  to pmem write mask; non-zero for exactly one cycle per write

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state IDLE, all valid/ready outputs 0, mem_rvalid 0, mem_wmask 0, rdata registers 0, latched addr/data 0.
- IDLE arbitration:
  - Grant goes to LSU if lsu_req_valid, else to IFU if ifu_req_valid (fixed priority).
  - The granted requester's req_ready is 1, combinationally from the valids; the other's req_ready is 0.
  - req_ready is 0 in every non-IDLE state.
- Acceptance edge (valid && ready):
  - Latch owner, addr, wen, wdata, wmask.
  - Load the counter with LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - mem_raddr/mem_waddr always show the latched addr; mem_wdata shows latched wdata.
  - In the WAIT cycle with counter==0:
    - Read: mem_rvalid=1 and mem_rdata is captured into the owner's rdata register at the edge.
    - Write: mem_wmask = latched mask, and rdata register = 0.
    - Then go to RESP.
  - In all other cycles, mem_rvalid=0 and mem_wmask=0. This is mandatory because the pmem write is combinational and must fire exactly once.
- RESP:
  - The owner's resp_valid=1, with rdata held stable.
  - On resp_ready, go to IDLE; the next grant is possible in the following cycle.
- Latency: response valid exactly LATENCY+1 cycles after the acceptance edge; back-to-back throughput is one transaction per LATENCY+2 cycles with resp_ready held high.
- Requests arriving in WAIT/RESP are held off (ready=0) and are not lost as long as the requester holds valid.
- Zero-mask LSU write: sequenced normally; mem_wmask stays 0 and an ack is still returned.
- Reset mid-operation: return to IDLE next edge and drop the transaction with no response. During any cycle with reset=1, mem_rvalid and mem_wmask are forced to 0 combinationally.
- Non-owner resp_valid is always 0.
- Addresses pass through unmodified; alignment is the memory model's job.

Optional Feature:
- Macro: PMEM_ARB_RR_EN.
- Defined: round-robin arbitration using a 1-bit last_owner register (reset = IFU).
  - When both requesters are valid in IDLE, grant the one that was not last_owner.
  - last_owner updates on each acceptance edge.
- Undefined: fixed LSU-over-IFU priority as above; no last_owner register.

Test Plan:
- IFU read, LATENCY=1, ifu_addr=0x80000000, mem_rdata=0x00000013_00000297 -> ifu_req_ready=1 at cycle 0; mem_rvalid=1 only in cycle 1; ifu_resp_valid=1 in cycle 2 with ifu_rdata=0x0000001300000297.
- LSU write, addr=0x80001000, wdata=0xDEADBEEF, mask=0x0F, LATENCY=3 -> mem_wmask=0x0F in exactly one cycle (cycle 3), 0 in all others; lsu_resp_valid in cycle 4 with lsu_rdata=0.
- Both valid in IDLE, macro undefined -> LSU granted first and IFU granted in the cycle after the LSU response handshake. Macro defined, after reset -> LSU first (last_owner=IFU), then IFU; with both continuously valid, grants alternate LSU, IFU, LSU.
- Response backpressure: hold ifu_resp_ready=0 for 5 cycles -> ifu_resp_valid and ifu_rdata stable, both req_ready=0, no additional mem_rvalid pulses.
- Assert reset in a WAIT cycle of a write with LATENCY=2 -> mem_wmask never non-zero; no lsu_resp_valid; all outputs at reset values next cycle.
- Back-to-back IFU reads with ifu_resp_ready=1, LATENCY=1 -> acceptances every 3 cycles; each response carries the data present at its own mem_rvalid cycle.
